hf_conf_sequencer: RTL and testbench

Controller that owns the HF configuration state. It receives ARM SPI command frames (spck/mosi/ncs), synchronises them into the ck_1356meg domain, and decodes SET_CONFREG and TRACE_ENABLE. Major-mode changes are sequenced glitch-free: every mode mux is parked on "all off" (3'b111) for a programmable blanking interval before the new configuration is applied. Its conf_word, major_mode and trace_enable outputs drive the major-mode muxes and the per-mode submodules.

---
 rtl/hf_conf_sequencer_if.sv | 18 +
 rtl/hf_conf_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_hf_conf_sequencer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hf_conf_sequencer_if.sv
// ----------------------------------------------------------------------------
// hf_conf_sequencer_if
// Groups the ARM SPI command link that feeds the HF configuration sequencer.
//   spck : SPI clock from the ARM, asynchronous to ck_1356meg
//   mosi : SPI data, valid on spck rise
//   ncs  : SPI chip select, active low, asynchronous
// Modports:
//   master : the ARM side (drives all three lines)
//   slave  : the sequencer side (samples all three lines)
// ----------------------------------------------------------------------------
interface hf_conf_sequencer_if;
    logic spck;
    logic mosi;
    logic ncs;

    modport master (output spck, output mosi, output ncs);
    modport slave  (input  spck, input  mosi, input  ncs);
endinterface

// File: rtl/hf_conf_sequencer.sv
// ----------------------------------------------------------------------------
// hf_conf_sequencer
// Owns the HF configuration state. Receives 16-bit ARM SPI command frames,
// brings them into the ck_1356meg domain, decodes SET_CONFREG and
// TRACE_ENABLE, and sequences major-mode changes so that the mode muxes are
// parked on "all off" (3'b111) for BLANK_CYCLES clocks between two different
// active modes.
// Ports:
//   ck_1356meg   in   sole clock, rising edge
//   nrst         in   synchronous active-low reset
//   spi          slave modport: spck / mosi / ncs from the ARM
//   conf_word    out  applied configuration; [7:5] major mode, [4:0] minor
//   major_mode   out  always conf_word[7:5]
//   trace_enable out  trace capture enable
//   busy         out  high while a blanking interval is running
//   cmd_strobe   out  one-cycle pulse per accepted 16-bit frame
//   frame_err    out  one-cycle pulse per frame with a bad bit count
// ----------------------------------------------------------------------------
module hf_conf_sequencer #(
    parameter int BLANK_CYCLES = 64,
    parameter int CNT_W        = 8
) (
    input  logic                      ck_1356meg,
    input  logic                      nrst,
    hf_conf_sequencer_if.slave        spi,
    output logic [7:0]                conf_word,
    output logic [2:0]                major_mode,
    output logic                      trace_enable,
    output logic                      busy,
    output logic                      cmd_strobe,
    output logic                      frame_err
);

    typedef enum logic {S_IDLE, S_BLANK} state_t;

    localparam logic [3:0]       OP_SET_CONFREG  = 4'b0001;
    localparam logic [3:0]       OP_TRACE_ENABLE = 4'b0010;
    localparam logic [7:0]       CONF_OFF        = 8'hE0;
    localparam logic [2:0]       MODE_OFF        = 3'b111;
    localparam logic [CNT_W-1:0] BLANK_LOAD      = CNT_W'(BLANK_CYCLES - 1);

    // Two-flop synchronisers; bit [1] is the synchronised value. mosi uses
    // the same depth as spck so data stays aligned with the detected edge.
    logic [1:0]       r_spck_sync;
    logic [1:0]       r_mosi_sync;
    logic [1:0]       r_ncs_sync;
    logic             r_spck_d;
    logic             r_ncs_d;
    logic [15:0]      r_shift;
    logic [4:0]       r_bit_cnt;

    logic             r_trace;
    logic             r_cmd_strobe;
    logic             r_frame_err;
    state_t           r_state;
    logic [7:0]       r_conf;
    logic [7:0]       r_pending;
    logic [CNT_W-1:0] r_cnt;

    logic             w_spck_rise;
    logic             w_ncs_rise;
    logic             w_ncs_fall;
    logic             w_frame_ok;
    logic             w_frame_bad;
    logic             w_set_conf;
    logic             w_set_trace;
    logic [7:0]       w_new_conf;
    state_t           w_state_nxt;
    logic [7:0]       w_conf_nxt;
    logic [7:0]       w_pending_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_spck_rise = r_spck_sync[1] & ~r_spck_d;
    assign w_ncs_rise  = r_ncs_sync[1] & ~r_ncs_d;
    assign w_ncs_fall  = ~r_ncs_sync[1] & r_ncs_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            r_spck_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_ncs_sync  <= 2'b11;   // idle-high, so leaving reset is no edge
            r_spck_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
        end else begin
            r_spck_sync <= {r_spck_sync[0], spi.spck};
            r_mosi_sync <= {r_mosi_sync[0], spi.mosi};
            r_ncs_sync  <= {r_ncs_sync[0], spi.ncs};
            r_spck_d    <= r_spck_sync[1];
            r_ncs_d     <= r_ncs_sync[1];
            if (w_ncs_fall) begin
                r_bit_cnt <= '0;
            end else if (w_spck_rise && !r_ncs_sync[1]) begin
                r_shift <= {r_shift[14:0], r_mosi_sync[1]};
                if (r_bit_cnt != 5'd31) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
        end
    end

    // Frame end is the synchronised ncs rise; only exactly 16 bits count.
    assign w_frame_ok  = w_ncs_rise && (r_bit_cnt == 5'd16);
    assign w_frame_bad = w_ncs_rise && (r_bit_cnt != 5'd16) && (r_bit_cnt != 5'd0);
    assign w_set_conf  = w_frame_ok && (r_shift[15:12] == OP_SET_CONFREG);
    assign w_set_trace = w_frame_ok && (r_shift[15:12] == OP_TRACE_ENABLE);
    assign w_new_conf  = r_shift[7:0];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_conf_nxt    = r_conf;
        w_pending_nxt = r_pending;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_set_conf) begin
                    // Safe to apply directly when the mode is unchanged or
                    // either side of the change is already "all off".
                    if (w_new_conf[7:5] == r_conf[7:5] ||
                        w_new_conf[7:5] == MODE_OFF ||
                        r_conf[7:5] == MODE_OFF) begin
                        w_conf_nxt = w_new_conf;
                    end else begin
                        w_conf_nxt    = CONF_OFF;
                        w_pending_nxt = w_new_conf;
                        w_cnt_nxt     = BLANK_LOAD;
                        w_state_nxt   = S_BLANK;
                    end
                end
            end
            S_BLANK: begin
                // A new frame takes priority over expiry in the same cycle.
                if (w_set_conf) begin
                    if (w_new_conf[7:5] == MODE_OFF) begin
                        w_conf_nxt  = w_new_conf;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_pending_nxt = w_new_conf;
                        w_cnt_nxt     = BLANK_LOAD;
                    end
                end else if (r_cnt == '0) begin
                    w_conf_nxt  = r_pending;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_conf       <= CONF_OFF;
            r_pending    <= '0;
            r_cnt        <= '0;
            r_trace      <= 1'b0;
            r_cmd_strobe <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_conf       <= w_conf_nxt;
            r_pending    <= w_pending_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cmd_strobe <= w_frame_ok;
            r_frame_err  <= w_frame_bad;
            if (w_set_trace) begin
                r_trace <= r_shift[0];
            end
        end
    end

    assign conf_word    = r_conf;
    assign major_mode   = r_conf[7:5];
    assign trace_enable = r_trace;
    assign busy         = (r_state == S_BLANK);
    assign cmd_strobe   = r_cmd_strobe;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_hf_conf_sequencer.sv
// ----------------------------------------------------------------------------
// tb_hf_conf_sequencer
// Two sequencer instances share one SPI link and reset: dut uses the default
// 64-cycle blank, dut_l a 160-cycle blank so that a second frame can arrive
// while the first blank is still running. The random scenario tracks dut_l
// with a timeline model: a list of (edge, conf_word, busy) entries derived
// from the command rules, plus lists of the edges where strobes are due.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hf_conf_sequencer;
    localparam int BLANK   = 64;
    localparam int BLANK_L = 160;

    logic clk = 1'b0;
    logic nrst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hf_conf_sequencer_if spi_if ();

    logic [7:0] conf_word,    conf_word_l;
    logic [2:0] major_mode,   major_mode_l;
    logic       trace_enable, trace_enable_l;
    logic       busy,         busy_l;
    logic       cmd_strobe,   cmd_strobe_l;
    logic       frame_err,    frame_err_l;

    hf_conf_sequencer #(.BLANK_CYCLES(BLANK), .CNT_W(8)) dut (
        .ck_1356meg(clk), .nrst(nrst), .spi(spi_if),
        .conf_word(conf_word), .major_mode(major_mode), .trace_enable(trace_enable),
        .busy(busy), .cmd_strobe(cmd_strobe), .frame_err(frame_err)
    );

    hf_conf_sequencer #(.BLANK_CYCLES(BLANK_L), .CNT_W(8)) dut_l (
        .ck_1356meg(clk), .nrst(nrst), .spi(spi_if),
        .conf_word(conf_word_l), .major_mode(major_mode_l), .trace_enable(trace_enable_l),
        .busy(busy_l), .cmd_strobe(cmd_strobe_l), .frame_err(frame_err_l)
    );

    // ---------------- reference model for dut_l ----------------
    typedef struct {
        int         at;
        logic [7:0] conf;
        logic       busy;
    } ent_t;

    ent_t tl[$];
    int   strobe_q[$];
    int   err_q[$];
    logic t_prev, t_val;
    int   t_edge;

    function automatic void model_reset(int c);
        tl.delete();
        tl.push_back('{c, 8'hE0, 1'b0});
        strobe_q.delete();
        err_q.delete();
        t_prev = 1'b0;
        t_val  = 1'b0;
        t_edge = c;
    endfunction

    function automatic ent_t exp_at(int c);
        for (int i = tl.size() - 1; i >= 0; i--) begin
            if (tl[i].at <= c) return tl[i];
        end
        return tl[0];
    endfunction

    function automatic logic exp_trace(int c);
        return (c >= t_edge) ? t_val : t_prev;
    endfunction

    // Frame decoded at edge d; future entries are discarded when a newer
    // command supersedes them.
    function automatic void model_frame(logic [31:0] bits, int n, int d);
        logic [15:0] w;
        logic [7:0]  nw;
        logic        blanking;
        ent_t        cur;
        w = bits[15:0];
        nw = w[7:0];
        if (n == 0) return;
        if (n != 16) begin
            err_q.push_back(d);
            return;
        end
        strobe_q.push_back(d);
        if (w[15:12] == 4'h2) begin
            t_prev = exp_trace(d - 1);
            t_val  = w[0];
            t_edge = d;
        end else if (w[15:12] == 4'h1) begin
            blanking = (tl[$].at >= d);
            while (tl.size() > 1 && tl[$].at >= d) void'(tl.pop_back());
            cur = tl[$];
            if (blanking) begin
                if (nw[7:5] == 3'b111) begin
                    tl.push_back('{d, nw, 1'b0});
                end else begin
                    tl.push_back('{d, 8'hE0, 1'b1});
                    tl.push_back('{d + BLANK_L, nw, 1'b0});
                end
            end else if (nw[7:5] == cur.conf[7:5] || nw[7:5] == 3'b111 ||
                         cur.conf[7:5] == 3'b111) begin
                tl.push_back('{d, nw, 1'b0});
            end else begin
                tl.push_back('{d, 8'hE0, 1'b1});
                tl.push_back('{d + BLANK_L, nw, 1'b0});
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        wait_cyc(2);
        nrst = 1'b1;
        model_reset(cyc);
    endtask

    // Sends bits[n-1:0] MSB first with ph-cycle spck phases and ncs margins.
    // Returns the edge at which the frame is decoded.
    task automatic send_frame(input logic [31:0] bits, input int n, input int ph,
                              output int d);
        wait_cyc(ph);
        spi_if.ncs = 1'b0;
        wait_cyc(ph);
        for (int i = n - 1; i >= 0; i--) begin
            spi_if.mosi = bits[i];
            wait_cyc(ph);
            spi_if.spck = 1'b1;
            wait_cyc(ph);
            spi_if.spck = 1'b0;
        end
        wait_cyc(ph);
        spi_if.ncs = 1'b1;
        d = cyc + 3;
        model_frame(bits, n, d);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        spi_if.ncs  = 1'b1;
        spi_if.spck = 1'b0;
        spi_if.mosi = 1'b0;
        nrst = 1'b0;
        wait_cyc(2);
        @(negedge clk);
        vectors++;
        if (conf_word !== 8'hE0) begin
            miscompares++; $display("FAIL reset_conf: got %h expected e0", conf_word);
        end
        vectors++;
        if (major_mode !== 3'b111) begin
            miscompares++; $display("FAIL reset_mode: got %b expected 111", major_mode);
        end
        vectors++;
        if ({trace_enable, busy, cmd_strobe, frame_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {trace_enable, busy, cmd_strobe, frame_err});
        end
        vectors++;
        if ({conf_word_l, trace_enable_l, busy_l} !== {8'hE0, 2'b00}) begin
            miscompares++; $display("FAIL reset_long: got %h/%b/%b expected e0/0/0",
                                    conf_word_l, trace_enable_l, busy_l);
        end
        nrst = 1'b1;
        model_reset(cyc);
        wait_cyc(1);
    endtask

    task automatic test_set_confreg();
        int d, s_cnt, b_cnt;
        do_reset();
        send_frame(32'h1021, 16, 4, d);
        s_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_cnt += int'(cmd_strobe);
            b_cnt += int'(busy);
            if (cyc == d - 1) begin
                vectors++;
                if (conf_word !== 8'hE0) begin
                    miscompares++; $display("FAIL set_early: got %h expected e0", conf_word);
                end
            end
            if (cyc == d) begin
                vectors++;
                if (conf_word !== 8'h21) begin
                    miscompares++; $display("FAIL set_apply: got %h expected 21", conf_word);
                end
            end
        end
        vectors++;
        if (s_cnt != 1) begin
            miscompares++; $display("FAIL set_strobes: got %0d expected 1", s_cnt);
        end
        vectors++;
        if (b_cnt != 0) begin
            miscompares++; $display("FAIL set_busy: got %0d expected 0", b_cnt);
        end
    endtask

    task automatic test_blank();
        int d, d0, n111, nbusy, first, last;
        do_reset();
        send_frame(32'h1021, 16, 4, d0);
        send_frame(32'h1041, 16, 4, d);
        n111 = 0; nbusy = 0; first = -1; last = -1;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (major_mode == 3'b111) begin
                n111++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            nbusy += int'(busy);
        end
        vectors++;
        if (n111 != BLANK) begin
            miscompares++; $display("FAIL blank_len: got %0d expected %0d", n111, BLANK);
        end
        vectors++;
        if (nbusy != BLANK) begin
            miscompares++; $display("FAIL blank_busy: got %0d expected %0d", nbusy, BLANK);
        end
        vectors++;
        if (first != d || last != d + BLANK - 1) begin
            miscompares++; $display("FAIL blank_window: got %0d..%0d expected %0d..%0d",
                                    first, last, d, d + BLANK - 1);
        end
        vectors++;
        if (conf_word !== 8'h41) begin
            miscompares++; $display("FAIL blank_final: got %h expected 41", conf_word);
        end
    endtask

    task automatic test_no_blank_trace();
        int d, d0, n111;
        do_reset();
        send_frame(32'h1041, 16, 4, d0);
        send_frame(32'h1049, 16, 4, d);
        n111 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (major_mode == 3'b111) n111++;
            if (cyc == d) begin
                vectors++;
                if (conf_word !== 8'h49) begin
                    miscompares++; $display("FAIL same_mode: got %h expected 49", conf_word);
                end
            end
        end
        vectors++;
        if (n111 != 0) begin
            miscompares++; $display("FAIL same_mode_blank: got %0d expected 0", n111);
        end
        send_frame(32'h2001, 16, 4, d);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cyc == d - 1) begin
                vectors++;
                if (trace_enable !== 1'b0) begin
                    miscompares++; $display("FAIL trace_early: got %b expected 0", trace_enable);
                end
            end
            if (cyc == d) begin
                vectors++;
                if ({trace_enable, conf_word} !== {1'b1, 8'h49}) begin
                    miscompares++; $display("FAIL trace_set: got %b/%h expected 1/49",
                                            trace_enable, conf_word);
                end
            end
        end
    endtask

    task automatic test_frame_errors();
        logic [31:0] fb [3];
        int          fn [3];
        int          d, n_err, n_str, n_chg;
        fb = '{32'h00021, 32'h11021, 32'h0};
        fn = '{12, 17, 0};
        n_err = 0; n_str = 0; n_chg = 0;
        for (int f = 0; f < 3; f++) begin
            send_frame(fb[f], fn[f], 4, d);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                n_err += int'(frame_err);
                n_str += int'(cmd_strobe);
                if (conf_word !== 8'h49 || trace_enable !== 1'b1 || busy !== 1'b0) n_chg++;
            end
        end
        vectors++;
        if (n_err != 2) begin
            miscompares++; $display("FAIL err_pulses: got %0d expected 2", n_err);
        end
        vectors++;
        if (n_str != 0) begin
            miscompares++; $display("FAIL err_strobes: got %0d expected 0", n_str);
        end
        vectors++;
        if (n_chg != 0) begin
            miscompares++; $display("FAIL err_state: got %0d changed cycles expected 0", n_chg);
        end
    endtask

    task automatic test_blank_restart();
        int d0, d1, d2;
        do_reset();
        send_frame(32'h1021, 16, 4, d0);
        send_frame(32'h1041, 16, 4, d1);
        send_frame(32'h1061, 16, 4, d2);
        while (cyc < d2 + BLANK_L + 4) begin
            @(negedge clk);
            if (cyc == d2 - 1 || cyc == d1 + BLANK_L || cyc == d2 + BLANK_L - 1) begin
                vectors++;
                if ({major_mode_l, busy_l} !== {3'b111, 1'b1}) begin
                    miscompares++; $display("FAIL restart_hold@%0d: got %b/%b expected 111/1",
                                            cyc - d1, major_mode_l, busy_l);
                end
            end
            if (cyc == d2 + BLANK_L) begin
                vectors++;
                if ({conf_word_l, busy_l} !== {8'h61, 1'b0}) begin
                    miscompares++; $display("FAIL restart_final: got %h/%b expected 61/0",
                                            conf_word_l, busy_l);
                end
            end
            if (cyc == d2 + BLANK) begin
                vectors++;
                if (conf_word !== 8'h61) begin
                    miscompares++; $display("FAIL restart_short: got %h expected 61", conf_word);
                end
            end
        end
    endtask

    task automatic test_reset_mid_blank();
        int d0, d1, bad;
        do_reset();
        send_frame(32'h1021, 16, 4, d0);
        send_frame(32'h1041, 16, 4, d1);
        wait_cyc(53);
        do_reset();
        bad = 0;
        for (int i = 0; i < BLANK_L + 20; i++) begin
            @(negedge clk);
            if (conf_word_l !== 8'hE0 || busy_l !== 1'b0 ||
                conf_word !== 8'hE0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++; $display("FAIL mid_blank_reset: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        do_reset();
        fork
            begin
                int          d, n, sel;
                logic [31:0] bits;
                for (int f = 0; f < 30; f++) begin
                    sel  = int'($urandom_range(0, 9));
                    bits = $urandom;
                    n    = 16;
                    case (sel)
                        0:       n = 0;
                        1:       n = int'($urandom_range(1, 15));
                        2:       n = int'($urandom_range(17, 20));
                        3:       bits[15:12] = 4'h2;
                        4:       bits[15:12] = 4'($urandom_range(3, 15));
                        default: bits[15:12] = 4'h1;
                    endcase
                    send_frame(bits, n, int'($urandom_range(3, 5)), d);
                end
                wait_cyc(BLANK_L + 10);
                done = 1'b1;
            end
            begin
                ent_t        e;
                logic        es, ee;
                logic [14:0] got, exp;
                while (!done) begin
                    @(negedge clk);
                    e  = exp_at(cyc);
                    while (strobe_q.size() > 0 && strobe_q[0] < cyc) void'(strobe_q.pop_front());
                    while (err_q.size() > 0 && err_q[0] < cyc) void'(err_q.pop_front());
                    es = (strobe_q.size() > 0 && strobe_q[0] == cyc);
                    ee = (err_q.size() > 0 && err_q[0] == cyc);
                    got = {conf_word_l, major_mode_l, trace_enable_l, busy_l,
                           cmd_strobe_l, frame_err_l};
                    exp = {e.conf, e.conf[7:5], exp_trace(cyc), e.busy, es, ee};
                    vectors++;
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL random@%0d: got conf/mode/trc/busy/stb/err %h/%b/%b/%b/%b/%b expected %h/%b/%b/%b/%b/%b",
                                 cyc, got[14:7], got[6:4], got[3], got[2], got[1], got[0],
                                 exp[14:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_set_confreg();
        test_blank();
        test_no_blank_trace();
        test_frame_errors();
        test_blank_restart();
        test_reset_mid_blank();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
